// File: rtl/link_test_pkg.sv
// Shared link-test definitions: checker state encoding, data width, default test-pattern seed.
// Used by both ends of the link so the pattern definition lives in one place.
package link_test_pkg;

    localparam int LINK_DATA_W = 32;
    localparam logic [LINK_DATA_W-1:0] LINK_SEED_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_PASS,
        ST_FAIL
    } chk_state_t;

    // Test pattern is a down-counter; wraps from 0 to all-ones.
    function automatic logic [LINK_DATA_W-1:0] pattern_next(input logic [LINK_DATA_W-1:0] cur);
        return cur - LINK_DATA_W'(1);
    endfunction

endpackage

// File: rtl/link_pattern_gen.sv
// Loadable 32-bit down-counter producing the link test pattern.
// Latency: value updates on the edge that samples load/step (load wins).
// Backpressure: none; step advances one word per asserted cycle.
module link_pattern_gen
    import link_test_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [LINK_DATA_W-1:0] load_value,
    input  logic                   step,
    output logic [LINK_DATA_W-1:0] value
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (step) begin
            value <= pattern_next(value);
        end
    end

endmodule

// File: rtl/link_rx_checker.sv
// Link receive checker: compares accepted words against the down-counter pattern, reports pass/fail.
// Latency: counts, captures and done/pass/led are registered, visible 1 cycle after the strobe.
// Backpressure: none; accepts a word every cycle. Watchdog under LINK_RX_CHECKER_TIMEOUT_EN.
module link_rx_checker
    import link_test_pkg::*;
#(
    parameter int                     RECEIVE_COUNT  = 100,
    parameter logic [LINK_DATA_W-1:0] SEED           = LINK_SEED_DEFAULT,
    parameter int                     ERR_W          = 16,
    parameter int                     TIMEOUT_CYCLES = 4096
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic [LINK_DATA_W-1:0]              data_in,
    input  logic                                valid_in,
    output logic [$clog2(RECEIVE_COUNT+1)-1:0]  word_count,
    output logic [ERR_W-1:0]                    err_count,
    output logic [LINK_DATA_W-1:0]              first_err_data,
    output logic [LINK_DATA_W-1:0]              first_err_exp,
    output logic                                done,
    output logic                                pass,
    output logic                                timeout,
    output logic                                led
);

    localparam int WC_W = $clog2(RECEIVE_COUNT + 1);

    chk_state_t             state;
    chk_state_t             state_nxt;
    logic [LINK_DATA_W-1:0] expected;
    logic                   start;
    logic                   accept;
    logic                   mismatch;
    logic                   last_word;
    logic                   run_clean;
    logic                   timeout_hit;

    assign start     = (state == ST_IDLE) && en;
    assign accept    = (state == ST_CHECK) && en && valid_in;
    assign mismatch  = accept && (data_in != expected);
    assign last_word = accept && (word_count == WC_W'(RECEIVE_COUNT - 1));
    // The final word's own mismatch must count toward the verdict.
    assign run_clean = (err_count == '0) && !mismatch;

    link_pattern_gen u_pattern (
        .clk        (clk),
        .rst        (rst),
        .load       (start),
        .load_value (SEED),
        .step       (accept),
        .value      (expected)
    );

`ifdef LINK_RX_CHECKER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    // Cycles elapsed since the last accepted word (or since entering CHECK).
    logic [IDLE_W-1:0] idle_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (start || accept) begin
            idle_cnt <= IDLE_W'(1);
        end else if (state == ST_CHECK) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    assign timeout_hit = (state == ST_CHECK) && en && !valid_in &&
                         (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end else if (last_word) begin
                    state_nxt = run_clean ? ST_PASS : ST_FAIL;
                end else if (timeout_hit) begin
                    state_nxt = ST_FAIL;
                end
            end
            ST_PASS, ST_FAIL: begin
                if (!en) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Results persist through PASS/FAIL and IDLE; only a new run clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_count     <= '0;
            err_count      <= '0;
            first_err_data <= '0;
            first_err_exp  <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
        end else if (start) begin
            word_count     <= '0;
            err_count      <= '0;
            first_err_data <= '0;
            first_err_exp  <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
        end else if (accept) begin
            word_count <= word_count + WC_W'(1);
            if (mismatch) begin
                if (!(&err_count)) begin
                    err_count <= err_count + ERR_W'(1);
                end
                if (err_count == '0) begin
                    first_err_data <= data_in;
                    first_err_exp  <= expected;
                end
            end
            if (last_word) begin
                done <= 1'b1;
                pass <= run_clean;
            end
        end else if (timeout_hit) begin
            done    <= 1'b1;
            timeout <= 1'b1;
        end
    end

    assign led = pass;

endmodule

// File: tb/tb_link_rx_checker.sv
// Bench for link_rx_checker: wrap/fault vector table on a small instance, model-checked runs on a full-size one.
module tb_link_rx_checker;

    localparam int          A_RC   = 100;
    localparam int          A_WCW  = $clog2(A_RC + 1);
    localparam logic [31:0] A_SEED = 32'hFFFF_FFFF;
    localparam int          B_WCW  = $clog2(5 + 1);
    localparam int          NVEC   = 26;
    localparam int          M_IDLE = 0;
    localparam int          M_CHECK = 1;
    localparam int          M_END  = 2;

    logic clk = 1'b0;
    logic rst;

    logic             a_en, a_valid;
    logic [31:0]      a_data;
    logic [A_WCW-1:0] a_wc;
    logic [15:0]      a_ec;
    logic [31:0]      a_fd, a_fe;
    logic             a_done, a_pass, a_to, a_led;

    logic             b_en, b_valid;
    logic [31:0]      b_data;
    logic [B_WCW-1:0] b_wc;
    logic [15:0]      b_ec;
    logic [31:0]      b_fd, b_fe;
    logic             b_done, b_pass, b_to, b_led;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    link_rx_checker #(
        .RECEIVE_COUNT (A_RC),
        .SEED          (A_SEED),
        .ERR_W         (16),
        .TIMEOUT_CYCLES(16)
    ) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .data_in(a_data), .valid_in(a_valid),
        .word_count(a_wc), .err_count(a_ec), .first_err_data(a_fd), .first_err_exp(a_fe),
        .done(a_done), .pass(a_pass), .timeout(a_to), .led(a_led)
    );

    link_rx_checker #(
        .RECEIVE_COUNT (5),
        .SEED          (32'h0000_0002),
        .ERR_W         (16),
        .TIMEOUT_CYCLES(4096)
    ) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .data_in(b_data), .valid_in(b_valid),
        .word_count(b_wc), .err_count(b_ec), .first_err_data(b_fd), .first_err_exp(b_fe),
        .done(b_done), .pass(b_pass), .timeout(b_to), .led(b_led)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- vector table for the SEED=2, 5-word instance ----------------
    typedef struct {
        logic             en;
        logic             valid;
        logic [31:0]      data;
        logic [B_WCW-1:0] wc;
        logic [15:0]      ec;
        logic [31:0]      fd;
        logic [31:0]      fe;
        logic             dn;
        logic             ps;
    } vec_t;

    vec_t vec[NVEC];

    function automatic vec_t mk(input logic en, input logic valid, input logic [31:0] data,
                                input int wc, input int ec, input logic [31:0] fd,
                                input logic [31:0] fe, input logic dn, input logic ps);
        vec_t v;
        v.en = en; v.valid = valid; v.data = data;
        v.wc = B_WCW'(wc); v.ec = 16'(ec); v.fd = fd; v.fe = fe; v.dn = dn; v.ps = ps;
        return v;
    endfunction

    // ---------------- reference model for the full-size instance ----------------
    // Words accepted in the current run; results are derived from this list alone.
    logic [31:0] m_q[$];
    bit          m_done  = 1'b0;
    int          m_phase = M_IDLE;

    function automatic void model_step(input logic en, input logic valid, input logic [31:0] data);
        case (m_phase)
            M_IDLE: if (en) begin
                m_q.delete();
                m_done  = 1'b0;
                m_phase = M_CHECK;
            end
            M_CHECK: if (!en) begin
                m_phase = M_IDLE;
            end else if (valid) begin
                m_q.push_back(data);
                if (m_q.size() == A_RC) begin
                    m_done  = 1'b1;
                    m_phase = M_END;
                end
            end
            default: if (!en) m_phase = M_IDLE;
        endcase
    endfunction

    function automatic logic [127:0] model_out();
        logic [A_WCW-1:0] wc;
        logic [15:0]      ec;
        logic [31:0]      fd, fe, want;
        logic             ps;
        wc = A_WCW'(m_q.size());
        ec = '0; fd = '0; fe = '0;
        foreach (m_q[i]) begin
            want = A_SEED - 32'(i);
            if (m_q[i] !== want) begin
                if (ec == '0) begin
                    fd = m_q[i];
                    fe = want;
                end
                if (ec != 16'hFFFF) ec = ec + 16'd1;
            end
        end
        ps = m_done && (ec == '0);
        return 128'({wc, ec, fd, fe, m_done, ps, ps, 1'b0});
    endfunction

    function automatic logic [127:0] a_outs();
        return 128'({a_wc, a_ec, a_fd, a_fe, a_done, a_pass, a_led, a_to});
    endfunction

    function automatic logic [127:0] b_outs();
        return 128'({b_wc, b_ec, b_fd, b_fe, b_done, b_pass, b_led, b_to});
    endfunction

    // Drive one cycle at the negedge, then compare on the following negedge.
    task automatic a_cycle(input logic en, input logic valid, input logic [31:0] data);
        a_en = en; a_valid = valid; a_data = data;
        @(negedge clk);
        model_step(en, valid, data);
        check("a_cycle", a_outs(), model_out());
    endtask

    task automatic a_run(input int n, input int bad_idx, input logic [31:0] bad_val);
        for (int i = 0; i < n; i++) begin
            a_cycle(1'b1, 1'b1, (i == bad_idx) ? bad_val : A_SEED - 32'(i));
        end
    endtask

    initial begin
        int          n;
        int          gap;
        int          guard;
        logic        v;
        logic [31:0] d;

        rst = 1'b1;
        a_en = 1'b0; a_valid = 1'b0; a_data = '0;
        b_en = 1'b0; b_valid = 1'b0; b_data = '0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_a", a_outs(), 128'(0));
        check("reset_b", b_outs(), 128'(0));
        rst = 1'b1;

        vec[0]  = mk(1'b1, 1'b1, 32'h2,         0, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        vec[1]  = mk(1'b1, 1'b1, 32'h2,         1, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        vec[2]  = mk(1'b1, 1'b1, 32'h1,         2, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        vec[3]  = mk(1'b1, 1'b0, 32'h0,         2, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        vec[4]  = mk(1'b1, 1'b1, 32'h0,         3, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        vec[5]  = mk(1'b1, 1'b1, 32'hFFFF_FFFF, 4, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        vec[6]  = mk(1'b1, 1'b1, 32'hFFFF_FFFE, 5, 0, 32'h0, 32'h0, 1'b1, 1'b1);
        vec[7]  = mk(1'b1, 1'b1, 32'hFFFF_FFFD, 5, 0, 32'h0, 32'h0, 1'b1, 1'b1);
        vec[8]  = mk(1'b0, 1'b0, 32'h0,         5, 0, 32'h0, 32'h0, 1'b1, 1'b1);
        vec[9]  = mk(1'b1, 1'b0, 32'h0,         0, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        vec[10] = mk(1'b1, 1'b1, 32'h2,         1, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        vec[11] = mk(1'b1, 1'b1, 32'h1,         2, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        vec[12] = mk(1'b1, 1'b1, 32'h7,         3, 1, 32'h7, 32'h0, 1'b0, 1'b0);
        vec[13] = mk(1'b1, 1'b1, 32'hFFFF_FFFF, 4, 1, 32'h7, 32'h0, 1'b0, 1'b0);
        vec[14] = mk(1'b1, 1'b1, 32'h5,         5, 2, 32'h7, 32'h0, 1'b1, 1'b0);
        vec[15] = mk(1'b0, 1'b1, 32'hFFFF_FFFD, 5, 2, 32'h7, 32'h0, 1'b1, 1'b0);
        vec[16] = mk(1'b1, 1'b0, 32'h0,         0, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        vec[17] = mk(1'b1, 1'b1, 32'h2,         1, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        vec[18] = mk(1'b0, 1'b1, 32'h1,         1, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        vec[19] = mk(1'b1, 1'b0, 32'h0,         0, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        vec[20] = mk(1'b1, 1'b1, 32'h2,         1, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        vec[21] = mk(1'b1, 1'b1, 32'h1,         2, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        vec[22] = mk(1'b1, 1'b1, 32'h0,         3, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        vec[23] = mk(1'b1, 1'b1, 32'hFFFF_FFFF, 4, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        vec[24] = mk(1'b1, 1'b1, 32'h0,         5, 1, 32'h0, 32'hFFFF_FFFE, 1'b1, 1'b0);
        vec[25] = mk(1'b0, 1'b0, 32'h0,         5, 1, 32'h0, 32'hFFFF_FFFE, 1'b1, 1'b0);

        for (int i = 0; i < NVEC; i++) begin
            b_en = vec[i].en; b_valid = vec[i].valid; b_data = vec[i].data;
            @(negedge clk);
            check($sformatf("vec%0d_wc", i), 128'(b_wc), 128'(vec[i].wc));
            check($sformatf("vec%0d_ec", i), 128'(b_ec), 128'(vec[i].ec));
            check($sformatf("vec%0d_first", i), 128'({b_fd, b_fe}), 128'({vec[i].fd, vec[i].fe}));
            check($sformatf("vec%0d_flags", i), 128'({b_done, b_pass, b_led, b_to}),
                  128'({vec[i].dn, vec[i].ps, vec[i].ps, 1'b0}));
        end
        b_en = 1'b0; b_valid = 1'b0;

        // Clean back-to-back run
        a_cycle(1'b1, 1'b0, 32'h0);
        a_run(A_RC, -1, 32'h0);
        check("clean_wc", 128'(a_wc), 128'(100));
        check("clean_ec", 128'(a_ec), 128'(0));
        check("clean_flags", 128'({a_done, a_pass, a_led, a_to}), 128'(4'b1110));
        a_cycle(1'b0, 1'b0, 32'h0);

        // Word 5 corrupted to zero
        a_cycle(1'b1, 1'b0, 32'h0);
        a_run(A_RC, 5, 32'h0);
        check("bad5_ec", 128'(a_ec), 128'(1));
        check("bad5_first_data", 128'(a_fd), 128'(32'h0));
        check("bad5_first_exp", 128'(a_fe), 128'(32'hFFFF_FFFA));
        check("bad5_flags", 128'({a_done, a_pass, a_led, a_to}), 128'(4'b1000));
        a_cycle(1'b0, 1'b0, 32'h0);

        // Abort after 40 words, then a full clean run
        a_cycle(1'b1, 1'b0, 32'h0);
        a_run(40, -1, 32'h0);
        a_cycle(1'b0, 1'b0, 32'h0);
        a_cycle(1'b0, 1'b1, A_SEED);
        a_cycle(1'b1, 1'b0, 32'h0);
        check("restart_wc", 128'(a_wc), 128'(0));
        a_run(A_RC, -1, 32'h0);
        check("restart_wc_final", 128'(a_wc), 128'(100));
        check("restart_pass", 128'({a_done, a_pass}), 128'(2'b11));
        a_cycle(1'b0, 1'b0, 32'h0);

        // Silence after 10 words
        a_cycle(1'b1, 1'b0, 32'h0);
        a_run(10, -1, 32'h0);
`ifdef LINK_RX_CHECKER_TIMEOUT_EN
        n = 1;
        a_valid = 1'b0;
        while (!a_to && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", 128'(n), 128'(16));
        check("timeout_flags", 128'({a_done, a_pass, a_led, a_to}), 128'(4'b1001));
        a_en = 1'b0;
        @(negedge clk);
        m_phase = M_IDLE;
`else
        for (int i = 0; i < 40; i++) a_cycle(1'b1, 1'b0, 32'h0);
        check("no_timeout", 128'({a_done, a_to}), 128'(0));
        a_cycle(1'b0, 1'b0, 32'h0);
`endif

        // Randomized runs: gaps, occasional aborts, error injection on odd runs
        for (int r = 0; r < 6; r++) begin
            gap = 0;
            guard = 0;
            a_cycle(1'b1, 1'b0, 32'h0);
            while (m_phase != M_END && guard < 600) begin
                v = ($urandom_range(0, 3) != 0) || (gap >= 3);
                gap = v ? 0 : gap + 1;
                d = A_SEED - 32'(m_q.size());
                if (r[0] && $urandom_range(0, 29) == 0) d = d ^ ($urandom | 32'h1);
                if ($urandom_range(0, 299) == 0) a_cycle(1'b0, 1'b0, 32'h0);
                else a_cycle(1'b1, v, v ? d : $urandom);
                guard++;
            end
            check($sformatf("rand%0d_done", r), 128'(a_done), 128'(1));
            for (int k = 0; k < 3; k++) a_cycle(1'b1, 1'b1, $urandom);
            a_cycle(1'b0, 1'b0, 32'h0);
        end

        // Asynchronous reset mid-run
        a_cycle(1'b1, 1'b0, 32'h0);
        a_run(20, 3, 32'h1234_5678);
        a_en = 1'b0; a_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_rst_a", a_outs(), 128'(0));
        check("async_rst_b", b_outs(), 128'(0));
        m_q.delete();
        m_done  = 1'b0;
        m_phase = M_IDLE;
        @(negedge clk);
        rst = 1'b1;
        a_cycle(1'b0, 1'b0, 32'h0);
        a_cycle(1'b1, 1'b0, 32'h0);
        a_run(5, -1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/link_rx_checker.md
# link_rx_checker

Downstream consumer of the FPGA 2 receiver's recovered data in the FPGA-to-FPGA link test. It checks every word accepted over the req/ack/rdy link against the sender-side test pattern: a 32-bit down-counter starting at `SEED` and decrementing by one per word. It counts received words and mismatches, declares pass or fail after `RECEIVE_COUNT` words, and drives the board LED.

## Interface
Parameters:
- `RECEIVE_COUNT`, 100: words per test run; must be ≥1.
- `SEED`, 32'hFFFF_FFFF: first expected word.
- `ERR_W`, 16: error counter width.
- `TIMEOUT_CYCLES`, 4096: watchdog limit (only used with `LINK_RX_CHECKER_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  test enable; level-sensitive.
- `data_in`  in  32  word from receiver `data_out`.
- `valid_in`  in  1  one-cycle strobe; high in the cycle the receiver accepts a word (req and ack both high).
- `word_count`  out  `$clog2(RECEIVE_COUNT+1)`  words checked this run.
- `err_count`  out  `ERR_W`  mismatches; saturates at all-ones.
- `first_err_data`  out  32  first mismatching received word.
- `first_err_exp`  out  32  expected value at the first mismatch.
- `done`  out  1  run finished (pass or fail).
- `pass`  out  1  run finished with zero errors and no timeout.
- `timeout`  out  1  watchdog fired.
- `led`  out  1  equals `pass`.

## Operation
- States: IDLE, CHECK, PASS, FAIL.
- IDLE:
  - `en`=1 → CHECK; load `expected`=`SEED` and clear all counters, captures, and flags.
  - `valid_in` is ignored.
- CHECK:
  - Each `valid_in` compares `data_in` with `expected`.
  - On mismatch, increment `err_count` (saturating). If this is the first error, capture `first_err_data`/`first_err_exp`.
  - Every valid word increments `word_count` and sets `expected` ← `expected`−1, modulo 2^32 (0 wraps to 32'hFFFF_FFFF).
  - The valid word that makes `word_count`=`RECEIVE_COUNT` moves the FSM to PASS if the final error total is 0, else FAIL. That word's own mismatch counts toward the total.
- PASS/FAIL:
  - Hold all results; ignore `valid_in`.
  - `en`=0 → IDLE.
- `en`=0 during CHECK → IDLE immediately; the partial run is discarded and counters are cleared on the next entry to CHECK.
- A `valid_in` in the same cycle that `en` falls is ignored.
- Reset (any state, asynchronous) → IDLE. All outputs reset to 0: counts, captures, `done`, `pass`, `timeout`, `led`.

## Timing
- All outputs are registered.
- The IDLE→CHECK transition takes one cycle. `valid_in` is accepted from the first cycle the state is CHECK.
- `word_count`/`err_count`/captures update on the clock edge that samples `valid_in`, so they are visible the next cycle.
- `done`, `pass`, and `led` assert on the same edge as the final `word_count` update: 1 cycle after the last valid strobe.
- Back-to-back `valid_in` (every cycle) is supported with no stall; the block has no backpressure.

## Configuration
- `LINK_RX_CHECKER_TIMEOUT_EN` defined:
  - In CHECK, a cycle counter clears on each `valid_in` and increments otherwise.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to FAIL with `timeout`=1 and `done`=1.
  - A `valid_in` in the terminal cycle takes precedence and counts normally.
- Macro undefined: no watchdog logic; `timeout` is tied 0 and CHECK waits indefinitely.

## Structure
- Shared package `link_test_pkg`:
  - state enum `chk_state_t`;
  - `LINK_DATA_W`=32;
  - default seed constant `LINK_SEED_DEFAULT`=32'hFFFF_FFFF.
- Sub-module `link_pattern_gen`: loadable 32-bit down-counter with `load`, `step`, and `value` ports. The sender-side stimulus generator reuses it so the two ends cannot diverge.

## Test plan
- Reset, `en`=1, 100 back-to-back correct words FFFF_FFFF…FFFF_FF9C → `done`=`pass`=`led`=1 one cycle after the last strobe; `word_count`=100, `err_count`=0.
- Same run with word 5 replaced by 0 → FAIL; `err_count`=1, `first_err_data`=0, `first_err_exp`=FFFF_FFFA, `pass`=0.
- `SEED`=2, `RECEIVE_COUNT`=5, words 2,1,0,FFFF_FFFF,FFFF_FFFE → pass (wrap-around).
- `en` dropped after 40 words, then re-raised with a full correct run → IDLE, counters cleared, then a clean pass with `word_count`=100.
- With the macro and `TIMEOUT_CYCLES`=16: 10 words, then silence → `timeout`=1, `done`=1, `pass`=0 exactly 16 cycles after the last strobe. Without the macro, `timeout` stays 0.
- Assert `rst` low mid-CHECK → all outputs 0 asynchronously, before the next clock edge.
